// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one main-memory port between the I-cache fill FSM,
//                the D-cache fill FSM and D-cache write-through stores.
//                Tracks outstanding reads and steers each returning data
//                valid strobe back to the fill that issued it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache fill side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_data_valid,
  // D-cache fill side
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_data_valid,
  // D-cache write-through stores
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wack,
  // Memory port
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  // Status
  output logic              spurious_err
);

  // The outstanding counter is 3 bits, so a latency above 7 could overflow it.
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISERV = 3'd1,
    DSERV = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       spurious_q, spurious_d;

  logic       w_issue;
  logic       w_ret;
  logic       w_cnt_zero;

  assign w_cnt_zero = (cnt_q == 3'd0);
  assign w_issue    = mem_en & ~mem_wr;
  // A valid only counts when a read is actually in flight; otherwise it is dropped.
  assign w_ret      = mem_data_valid & ~w_cnt_zero;

  // Route each counted return to the side that owns the port until its drain ends.
  assign i_data_valid = w_ret & (owner_q == OWN_I);
  assign d_data_valid = w_ret & (owner_q == OWN_D);
  assign spurious_err = spurious_q;

  // Next-state, grant and memory-port decode.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    d_wack       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (!w_cnt_zero) begin
          // Reads still in flight: hold the previous owner and finish draining.
          i_gnt   = (owner_q == OWN_I);
          d_gnt   = (owner_q == OWN_D);
          state_d = DRAIN;
        end else if (d_wr) begin
          state_d = WRITE;
        end else if (d_req && !(last_owner_q == OWN_D && i_req)) begin
          // D fill wins unless D had the last fill and I is waiting.
          state_d = DSERV;
          owner_d = OWN_D;
        end else if (i_req) begin
          state_d = ISERV;
          owner_d = OWN_I;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_waddr;
        mem_wdata = d_wdata;
        d_wack    = 1'b1;
        state_d   = IDLE;
      end

      ISERV: begin
        i_gnt = 1'b1;
        if (i_req) begin
          mem_en   = 1'b1;
          mem_addr = i_addr;
        end else begin
          last_owner_d = OWN_I;
          state_d      = DRAIN;
        end
      end

      DSERV: begin
        d_gnt = 1'b1;
        if (d_req) begin
          mem_en   = 1'b1;
          mem_addr = d_addr;
        end else begin
          last_owner_d = OWN_D;
          state_d      = DRAIN;
        end
      end

      DRAIN: begin
        i_gnt = (owner_q == OWN_I);
        d_gnt = (owner_q == OWN_D);
        if (w_cnt_zero) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding-read counter and sticky spurious-return flag.
  always_comb begin
    cnt_d = cnt_q;
    case ({w_issue, w_ret})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    spurious_d = spurious_q | (mem_data_valid & w_cnt_zero);
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      spurious_q   <= spurious_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Fill and store tasks push
//                the expected memory transactions; a negedge monitor pops and
//                compares them and checks return routing against a tagged
//                fixed-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 4;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_I    = 2'd1;
  localparam logic [1:0] TAG_D    = 2'd2;
  localparam logic [1:0] TAG_DROP = 2'd3;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        side;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr, d_waddr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_gnt, d_gnt, i_data_valid, d_data_valid, d_wack;
  logic              mem_en, mem_wr, mem_data_valid, spurious_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              inj_valid;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   idv_cnt = 0, ddv_cnt = 0, idv_last = -1, ddv_last = -1;
  logic mon_on = 1'b0;

  txn_t       exp_q[$];
  logic [1:0] rd_tag_n;
  logic [1:0] tag_pipe [MEM_LAT];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_data_valid(d_data_valid),
    .d_wr(d_wr), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wack(d_wack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Fixed-latency memory: a read issued in cycle t returns in cycle t+MEM_LAT.
  // Reads in flight across a reset become DROP: they must not be routed.
  always @(posedge clk) begin
    if (!mon_on) begin
      for (int j = 0; j < MEM_LAT; j++) tag_pipe[j] <= TAG_NONE;
    end else begin
      for (int j = MEM_LAT - 1; j > 0; j--)
        tag_pipe[j] <= (rst && tag_pipe[j-1] != TAG_NONE) ? TAG_DROP : tag_pipe[j-1];
      tag_pipe[0] <= (rst && rd_tag_n != TAG_NONE) ? TAG_DROP : rd_tag_n;
    end
  end

  assign mem_data_valid = (tag_pipe[MEM_LAT-1] != TAG_NONE) || inj_valid;

  // Monitor: pop expected transactions on every memory access, check routing.
  always @(negedge clk) begin
    txn_t e;
    if (mon_on) begin
      if (mem_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 32'd1, 32'd0);
          rd_tag_n <= mem_wr ? TAG_NONE : TAG_DROP;
        end else begin
          e = exp_q.pop_front();
          chk("mem_wr", 32'(mem_wr), 32'(e.wr));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.wr) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
          rd_tag_n <= mem_wr ? TAG_NONE : e.side;
        end
      end else begin
        rd_tag_n <= TAG_NONE;
      end
      if (mem_data_valid || i_data_valid || d_data_valid) begin
        chk("i_data_valid", 32'(i_data_valid), 32'(mem_data_valid && tag_pipe[MEM_LAT-1] == TAG_I));
        chk("d_data_valid", 32'(d_data_valid), 32'(mem_data_valid && tag_pipe[MEM_LAT-1] == TAG_D));
      end
      if (i_data_valid) begin idv_cnt <= idv_cnt + 1; idv_last <= cyc; end
      if (d_data_valid) begin ddv_cnt <= ddv_cnt + 1; ddv_last <= cyc; end
    end else begin
      rd_tag_n <= TAG_NONE;
    end
  end

  // Fill FSM model: raises req, walks base+k, pushes one expected read per granted
  // cycle, then drops req. All calls start just after a rising edge.
  task automatic fill(input logic side_d, input int n, input logic [ADDR_W-1:0] base,
                      output int first_c, output int last_c);
    int k = 0;
    int guard = 0;
    first_c = -1;
    last_c  = -1;
    while ((side_d ? d_gnt : i_gnt) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (side_d) begin d_req = 1'b1; d_addr = base; end
    else        begin i_req = 1'b1; i_addr = base; end
    while (k < n && guard < 300) begin
      @(posedge clk); #1; guard++;
      if (side_d) d_addr = base + ADDR_W'(k);
      else        i_addr = base + ADDR_W'(k);
      if (side_d ? d_gnt : i_gnt) begin
        exp_q.push_back('{wr: 1'b0, addr: base + ADDR_W'(k), data: '0,
                          side: (side_d ? TAG_D : TAG_I)});
        if (k == 0) first_c = cyc;
        last_c = cyc;
        k++;
      end
    end
    chk(side_d ? "d_fill_issued" : "i_fill_issued", 32'(k), 32'(n));
    @(posedge clk); #1;
    if (side_d) d_req = 1'b0;
    else        i_req = 1'b0;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dt, output int s_c);
    int guard = 0;
    s_c = -1;
    d_wr = 1'b1; d_waddr = a; d_wdata = dt;
    while (s_c < 0 && guard < 100) begin
      @(posedge clk); #1; guard++;
      if (d_wack) begin
        exp_q.push_back('{wr: 1'b1, addr: a, data: dt, side: TAG_NONE});
        s_c = cyc;
      end
    end
    chk("store_acked", 32'(s_c >= 0), 32'd1);
    @(posedge clk); #1;
    d_wr = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    int guard = 0;
    while ((i_gnt || d_gnt || mem_en) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("reached_idle", 32'(guard < 100), 32'd1);
    c = cyc;
  endtask

  initial begin
    int c0, f_i, l_i, f_d, l_d, s_c, ic, n0;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; inj_valid = 1'b0;
    i_addr = '0; d_addr = '0; d_waddr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_gnts", 32'({i_gnt, d_gnt, d_wack}), 32'd0);
    chk("rst_spurious", 32'(spurious_err), 32'd0);
    mon_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1/5: lone I fill of 8; later issues overlap earlier returns.
    c0 = cyc; n0 = idv_cnt;
    fill(1'b0, 8, 16'h1000, f_i, l_i);
    chk("t1_first_issue", 32'(f_i), 32'(c0 + 1));
    wait_idle(ic);
    chk("t1_idle_cycle", 32'(ic), 32'(l_i + MEM_LAT + 2));
    chk("t1_idv_count", 32'(idv_cnt - n0), 32'd8);
    chk("t1_idv_last", 32'(idv_last), 32'(l_i + MEM_LAT));
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: simultaneous requests with last_owner=I -> D first, I after D drain.
    c0 = cyc;
    fork
      fill(1'b1, 4, 16'h2000, f_d, l_d);
      fill(1'b0, 4, 16'h1100, f_i, l_i);
    join
    chk("t2_d_first", 32'(f_d), 32'(c0 + 1));
    chk("t2_i_after_drain", 32'(f_i), 32'(l_d + MEM_LAT + 3));
    wait_idle(ic);
    // 2b: D request arriving mid I fill waits for the I drain.
    fork
      fill(1'b0, 6, 16'h1200, f_i, l_i);
      begin
        repeat (3) @(posedge clk);
        #1;
        fill(1'b1, 3, 16'h2100, f_d, l_d);
      end
    join
    chk("t2b_i_keeps_gnt", 32'(f_d), 32'(l_i + MEM_LAT + 3));
    wait_idle(ic);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: store pending during an I fill goes out only after the I drain.
    fork
      fill(1'b0, 5, 16'h1300, f_i, l_i);
      begin
        repeat (2) @(posedge clk);
        #1;
        store(16'h3000, 16'hBEEF, s_c);
      end
    join
    chk("t3_store_cycle", 32'(s_c), 32'(l_i + MEM_LAT + 3));
    wait_idle(ic);

    // 6: D fill, then store, then I fill, in that order on the port.
    fill(1'b1, 4, 16'h2200, f_d, l_d);
    store(16'h3100, 16'h1234, s_c);
    fill(1'b0, 4, 16'h1400, f_i, l_i);
    chk("t6_store_after_d", 32'(s_c), 32'(l_d + MEM_LAT + 3));
    chk("t6_i_after_store", 32'(f_i), 32'(s_c + 2));
    wait_idle(ic);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_no_spurious", 32'(spurious_err), 32'd0);

    // 4: reset with 3 reads outstanding.
    n0 = idv_cnt;
    i_req = 1'b1; i_addr = 16'h4000;
    begin
      int k = 0;
      int guard = 0;
      while (k < 3 && guard < 50) begin
        @(posedge clk); #1; guard++;
        i_addr = 16'h4000 + ADDR_W'(k);
        if (i_gnt) begin
          exp_q.push_back('{wr: 1'b0, addr: 16'h4000 + ADDR_W'(k), data: '0, side: TAG_I});
          k++;
        end
      end
      chk("t4_three_issued", 32'(k), 32'd3);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b0;
    chk("t4_outputs_zero", 32'({mem_en, mem_wr, i_gnt, d_gnt, d_wack}), 32'd0);
    repeat (MEM_LAT + 2) @(posedge clk);
    #1;
    chk("t4_no_routing", 32'(idv_cnt - n0), 32'd0);
    chk("t4_spurious_set", 32'(spurious_err), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_spurious_cleared", 32'(spurious_err), 32'd0);

    // Stray valid while idle is dropped and flagged.
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    chk("inj_spurious_set", 32'(spurious_err), 32'd1);
    chk("inj_queue_empty", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
